// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared definitions for the pong match controller: state
//               encoding, winner codes, serve-direction constants and the
//               default winning score.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] c_WINNER_NONE  = 2'b00;
  localparam logic [1:0] c_WINNER_LEFT  = 2'b01;
  localparam logic [1:0] c_WINNER_RIGHT = 2'b10;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int c_DEFAULT_WIN_SCORE = 9;

endpackage
`default_nettype wire

// File: rtl/pong_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : pong_frame_timer
// Description : Detects the rising edge of vertical sync (one frame tick)
//               and runs a loadable 9-bit frame down-counter.
// Ports       : clk        in  pixel clock
//               rst_n      in  asynchronous active-low reset
//               i_vs       in  vertical sync level
//               i_load     in  load the counter (takes priority over a tick)
//               i_load_val in  9-bit value to load
//               o_tick     out one-cycle frame strobe
//               o_expire   out counter is on its final frame; the owning
//                              state ends on the next o_tick
// Revision    : 1.0 - initial release
// ============================================================================
module pong_frame_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_vs,
  input  logic       i_load,
  input  logic [8:0] i_load_val,
  output logic       o_tick,
  output logic       o_expire
);

  logic       r_vs_prev;
  logic [8:0] r_count;

  // Previous-sample register resets high so a release with vsync already
  // high never looks like an edge.
  assign o_tick   = i_vs & ~r_vs_prev;
  assign o_expire = (r_count == 9'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev <= 1'b1;
      r_count   <= 9'd0;
    end else begin
      r_vs_prev <= i_vs;
      if (i_load) begin
        r_count <= i_load_val;
      end else if (o_tick && (r_count != 9'd0)) begin
        // Holding at zero keeps untimed states from wrapping the counter.
        r_count <= r_count - 9'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_match_ctrl
// Description : Match sequencer for a two-player pong game. Handles start,
//               serve delay, play, point pause and game-over hold, keeps
//               the scores and reports the winner.
// Ports       : iVGA_CLK   in  pixel clock
//               iRST_n     in  asynchronous active-low reset
//               iVS        in  vertical sync (frame = rising edge)
//               start_in   in  start button level
//               miss_l     in  ball left via left edge (right scores)
//               miss_r     in  ball left via right edge (left scores)
//               ball_run   out ball engine may advance (PLAY only)
//               ball_reset out one-cycle recentre pulse
//               serve_dir  out next serve direction, 1 = rightward
//               score_l    out left player score
//               score_r    out right player score
//               winner     out 00 none, 01 left, 10 right
//               state      out current state code
// Revision    : 1.0 - initial release
// ============================================================================
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = c_DEFAULT_WIN_SCORE,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int OVER_FRAMES  = 300
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       iVS,
  input  logic       start_in,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [3:0] c_WIN_SCORE = 4'(WIN_SCORE);
  localparam logic [8:0] c_SERVE_N   = 9'(SERVE_FRAMES);
  localparam logic [8:0] c_POINT_N   = 9'(POINT_FRAMES);
  localparam logic [8:0] c_OVER_N    = 9'(OVER_FRAMES);

  state_t     r_state;
  logic       r_start_prev;
  logic       r_ball_run;
  logic       r_ball_reset;
  logic       r_serve_dir;
  logic [3:0] r_score_l;
  logic [3:0] r_score_r;
  logic [1:0] r_winner;

  logic       w_tick;
  logic       w_expire;
  logic       w_done;
  logic       w_start_stb;
  logic       w_l_only;
  logic       w_r_only;
  logic [3:0] w_score_l_inc;
  logic [3:0] w_score_r_inc;
  logic       w_left_wins;
  logic       w_right_wins;
  logic       w_load;
  logic [8:0] w_load_val;

  assign w_start_stb   = start_in & ~r_start_prev;
  assign w_done        = w_tick & w_expire;
  assign w_l_only      = miss_l & ~miss_r;
  assign w_r_only      = miss_r & ~miss_l;
  assign w_score_l_inc = r_score_l + 4'd1;
  assign w_score_r_inc = r_score_r + 4'd1;
  assign w_left_wins   = w_r_only & (w_score_l_inc == c_WIN_SCORE);
  assign w_right_wins  = w_l_only & (w_score_r_inc == c_WIN_SCORE);

  // The counter must be loaded on the same edge the FSM changes state, so
  // a tick arriving on the very next cycle is already counted against the
  // new state's duration. Untimed states (IDLE, PLAY) load zero.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = 9'd0;
    case (r_state)
      ST_IDLE: begin
        w_load     = w_start_stb;
        w_load_val = c_SERVE_N;
      end
      ST_SERVE: begin
        w_load     = w_done;
      end
      ST_PLAY: begin
        w_load     = miss_l | miss_r;
        w_load_val = (w_left_wins | w_right_wins) ? c_OVER_N : c_POINT_N;
      end
      ST_POINT: begin
        w_load     = w_done;
        w_load_val = c_SERVE_N;
      end
      ST_OVER: begin
        w_load     = w_done;
      end
      default: begin
        w_load     = 1'b1;
      end
    endcase
  end

  pong_frame_timer u_frame_timer (
    .clk        (iVGA_CLK),
    .rst_n      (iRST_n),
    .i_vs       (iVS),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tick     (w_tick),
    .o_expire   (w_expire)
  );

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state      <= ST_IDLE;
      r_start_prev <= 1'b1;
      r_ball_run   <= 1'b0;
      r_ball_reset <= 1'b0;
      r_serve_dir  <= DIR_RIGHT;
      r_score_l    <= 4'd0;
      r_score_r    <= 4'd0;
      r_winner     <= c_WINNER_NONE;
    end else begin
      r_start_prev <= start_in;
      r_ball_reset <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_score_l <= 4'd0;
          r_score_r <= 4'd0;
          r_winner  <= c_WINNER_NONE;
          if (w_start_stb) begin
            r_state      <= ST_SERVE;
            r_serve_dir  <= DIR_RIGHT;
            r_ball_reset <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (w_done) begin
            r_state    <= ST_PLAY;
            r_ball_run <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (miss_l | miss_r) begin
            r_ball_run <= 1'b0;
            // Next serve goes toward whoever just conceded; a double miss
            // is a dead ball and leaves score and direction alone.
            if (w_l_only) begin
              r_score_r   <= w_score_r_inc;
              r_serve_dir <= DIR_LEFT;
            end
            if (w_r_only) begin
              r_score_l   <= w_score_l_inc;
              r_serve_dir <= DIR_RIGHT;
            end
            if (w_right_wins) begin
              r_state  <= ST_OVER;
              r_winner <= c_WINNER_RIGHT;
            end else if (w_left_wins) begin
              r_state  <= ST_OVER;
              r_winner <= c_WINNER_LEFT;
            end else begin
              r_state  <= ST_POINT;
            end
          end
        end
        ST_POINT: begin
          if (w_done) begin
            r_state      <= ST_SERVE;
            r_ball_reset <= 1'b1;
          end
        end
        ST_OVER: begin
          if (w_done) begin
            r_state   <= ST_IDLE;
            r_score_l <= 4'd0;
            r_score_r <= 4'd0;
            r_winner  <= c_WINNER_NONE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_ball_run <= 1'b0;
        end
      endcase
    end
  end

  assign ball_run   = r_ball_run;
  assign ball_reset = r_ball_reset;
  assign serve_dir  = r_serve_dir;
  assign score_l    = r_score_l;
  assign score_r    = r_score_r;
  assign winner     = r_winner;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_match_ctrl
// Description : Self-checking bench for pong_match_ctrl. A game-level model
//               (global frame count, deadlines, integer scores) predicts
//               every output each cycle; directed scenes pin key values.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_match_ctrl;

  localparam int WIN = 3;
  localparam int SRV = 2;
  localparam int PNT = 3;
  localparam int OVR = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs    = 1'b0;
  logic       start = 1'b0;
  logic       ml    = 1'b0;
  logic       mr    = 1'b0;
  logic       ball_run;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] winner;
  logic [2:0] state;

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SRV),
    .POINT_FRAMES (PNT),
    .OVER_FRAMES  (OVR)
  ) dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .iVS        (vs),
    .start_in   (start),
    .miss_l     (ml),
    .miss_r     (mr),
    .ball_run   (ball_run),
    .ball_reset (ball_reset),
    .serve_dir  (serve_dir),
    .score_l    (score_l),
    .score_r    (score_r),
    .winner     (winner),
    .state      (state)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- game-level reference model ----------------
  // Phases: 0 idle, 1 serve, 2 play, 3 point, 4 over. Timed phases end when
  // the global frame count reaches a deadline set on entry.
  int m_phase, m_sl, m_sr, m_win, m_ticks, m_deadline;
  bit m_dir, m_run, m_brst, m_vs_prev, m_st_prev;

  task automatic m_enter(input int ph, input int frames);
    m_phase    = ph;
    m_deadline = m_ticks + frames;
  endtask

  always @(posedge clk) begin
    bit tick, stb, done;
    if (!rst_n) begin
      m_phase = 0; m_sl = 0; m_sr = 0; m_win = 0; m_ticks = 0;
      m_deadline = 0; m_dir = 1; m_run = 0; m_brst = 0;
      m_vs_prev = 1; m_st_prev = 1;
    end else begin
      tick = vs && !m_vs_prev;
      stb  = start && !m_st_prev;
      m_vs_prev = vs;
      m_st_prev = start;
      if (tick) m_ticks++;
      done   = tick && (m_ticks == m_deadline);
      m_brst = 0;
      case (m_phase)
        0: if (stb) begin m_enter(1, SRV); m_dir = 1; m_brst = 1; end
        1: if (done) m_phase = 2;
        2: begin
          if (ml && mr) m_enter(3, PNT);
          else if (ml) begin
            m_sr++; m_dir = 0;
            if (m_sr == WIN) begin m_win = 2; m_enter(4, OVR); end
            else m_enter(3, PNT);
          end else if (mr) begin
            m_sl++; m_dir = 1;
            if (m_sl == WIN) begin m_win = 1; m_enter(4, OVR); end
            else m_enter(3, PNT);
          end
        end
        3: if (done) begin m_enter(1, SRV); m_brst = 1; end
        4: if (done) begin m_phase = 0; m_sl = 0; m_sr = 0; m_win = 0; end
        default: m_phase = 0;
      endcase
      m_run = (m_phase == 2);
    end
  end

  // Cycle-by-cycle comparison, sampled just after the active edge.
  always @(posedge clk) begin
    int act, exp;
    #1;
    act = int'({state, ball_run, ball_reset, serve_dir, score_l, score_r, winner});
    exp = int'({m_phase[2:0], m_run, m_brst, m_dir, m_sl[3:0], m_sr[3:0], m_win[1:0]});
    chk("cycle", act, exp);
  end

  // ---------------- stimulus helpers ----------------
  task automatic frame();
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic miss(input logic l, input logic r);
    ml = l;
    mr = r;
    @(negedge clk);
    ml = 1'b0;
    mr = 1'b0;
  endtask

  // ---------------- directed scenes, then random play ----------------
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_dir", serve_dir, 1);
    chk("rst_scores", {score_l, score_r}, 0);
    chk("rst_winner", winner, 0);
    chk("rst_run", ball_run, 0);
    chk("rst_breset", ball_reset, 0);

    // Start -> serve -> play
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_breset", ball_reset, 1);
    chk("start_state", state, 1);
    @(negedge clk);
    chk("start_breset_off", ball_reset, 0);
    frame();
    chk("serve_mid", state, 1);
    frame();
    chk("serve_done", state, 2);
    chk("play_run", ball_run, 1);

    // Left scores, point pause, reserve
    miss(1'b0, 1'b1);
    chk("mr_score_l", score_l, 1);
    chk("mr_dir", serve_dir, 1);
    chk("mr_state", state, 3);
    chk("mr_run", ball_run, 0);
    frames(2);
    chk("point_mid", state, 3);
    vs = 1'b1;
    @(negedge clk);
    chk("point_done", state, 1);
    chk("point_breset", ball_reset, 1);
    vs = 1'b0;
    @(negedge clk);
    chk("point_breset_off", ball_reset, 0);
    repeat (2) @(negedge clk);
    frames(SRV);
    chk("replay", state, 2);

    // Double miss is a dead ball
    miss(1'b1, 1'b1);
    chk("dbl_state", state, 3);
    chk("dbl_score_l", score_l, 1);
    chk("dbl_score_r", score_r, 0);
    chk("dbl_dir", serve_dir, 1);
    frames(PNT + SRV);

    // Right wins with three points
    for (int i = 1; i <= WIN; i++) begin
      miss(1'b1, 1'b0);
      chk("ml_score_r", score_r, i);
      if (i < WIN) begin
        chk("ml_state", state, 3);
        chk("ml_dir", serve_dir, 0);
        frames(PNT + SRV);
      end
    end
    chk("over_winner", winner, 2);
    chk("over_state", state, 4);

    // Start held through game-over must not restart the match
    start = 1'b1;
    frames(OVR);
    chk("over_idle", state, 0);
    chk("over_clr", {score_l, score_r}, 0);
    chk("over_win_clr", winner, 0);
    repeat (5) @(negedge clk);
    chk("held_start", state, 0);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("restart", state, 1);
    start = 1'b0;

    // Reach POINT with score_l = 2, then reset mid-match
    frames(SRV);
    miss(1'b0, 1'b1);
    frames(PNT + SRV);
    miss(1'b0, 1'b1);
    chk("pre_rst_score_l", score_l, 2);
    chk("pre_rst_state", state, 3);
    rst_n = 1'b0;
    vs    = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_scores", {score_l, score_r}, 0);
    chk("mid_rst_dir", serve_dir, 1);
    chk("mid_rst_breset", ball_reset, 0);
    repeat (4) @(negedge clk);
    chk("rel_no_start", state, 0);
    chk("rel_no_breset", ball_reset, 0);
    vs    = 1'b0;
    start = 1'b0;
    @(negedge clk);

    // Randomised play
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 5) == 0) vs = ~vs;
      if ($urandom_range(0, 7) == 0) start = ~start;
      ml = ($urandom_range(0, 29) == 0);
      mr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 149) == 0) begin
        ml = 1'b1;
        mr = 1'b1;
      end
      rst_n = ($urandom_range(0, 999) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    ml    = 1'b0;
    mr    = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
